// File: rtl/tcp_rd_memory.sv
// rtl/tcp_rd_memory.sv - receive-side TCP payload buffer holding one in-order segment
// Optional feature macro: TCP_RD_DROP_CNT_EN (enables the saturating dropped-segment counter)
module tcp_rd_memory #(
  parameter int MAX_PACKET_SIZE = 1450
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        controller_idle_st_i,
  input  logic        init_i,
  input  logic [31:0] init_seq_i,
  input  logic        rcv_sop_i,
  input  logic        rcv_wr_i,
  input  logic [31:0] rcv_dat_i,
  input  logic        rcv_eop_i,
  input  logic [31:0] rcv_seq_num_i,
  input  logic [15:0] rcv_len_i,
  input  logic        rcv_chksum_ok_i,
  output logic [31:0] ack_num_o,
  output logic        ack_req_o,
  output logic        rd_valid_o,
  output logic [15:0] rd_len_o,
  input  logic        rd_i,
  output logic [31:0] rdat_o,
  input  logic        rd_done_i,
  output logic [15:0] drop_cnt_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  localparam logic [15:0] MAX_LEN = 16'(MAX_PACKET_SIZE);

  logic [1:0]  state;
  logic [8:0]  wr_addr;
  logic [8:0]  rd_addr;
  logic        overflow;
  logic [31:0] ram [0:511];

  // Control inputs that pre-empt all receive/read activity this cycle
  logic        ctrl_busy;
  logic        sop_accept;
  logic        write_word;
  logic        ram_we;
  logic [8:0]  ram_waddr;
  logic [9:0]  words_now;
  logic        ovf_now;
  logic [16:0] len_words;
  logic        seg_eop;
  logic        eop_event;
  logic        commit;
  logic        drop_eop;
  logic        rd_fire;
  logic        release_buf;

  // Segment qualification and commit decision, evaluated on the eop cycle
  always_comb begin
    ctrl_busy   = controller_idle_st_i | init_i;
    // Accept only the exact next expected sequence number into an empty buffer
    sop_accept  = (state == ST_IDLE) && rcv_sop_i && !rd_valid_o &&
                  (rcv_seq_num_i == ack_num_o);
    write_word  = (state == ST_WRITE) && rcv_wr_i;
    ram_we      = !ctrl_busy && (sop_accept || write_word);
    ram_waddr   = sop_accept ? 9'd0 : wr_addr;
    // Words stored including any word written on the eop cycle itself
    words_now   = sop_accept ? 10'd1 : ({1'b0, wr_addr} + {9'd0, rcv_wr_i});
    ovf_now     = overflow || (write_word && (wr_addr == 9'd511));
    len_words   = ({1'b0, rcv_len_i} + 17'd3) >> 2;
    // eop that closes a segment: from WRITE/DROP, or a single-word sop+eop in IDLE
    eop_event   = rcv_eop_i && ((state != ST_IDLE) || rcv_sop_i);
    seg_eop     = rcv_eop_i && ((state == ST_WRITE) || sop_accept);
    commit      = seg_eop && rcv_chksum_ok_i && (rcv_len_i != 16'd0) &&
                  (rcv_len_i <= MAX_LEN) && !ovf_now &&
                  (len_words == {7'd0, words_now});
    drop_eop    = eop_event && !commit;
    rd_fire     = rd_i && rd_valid_o;
    release_buf = rd_done_i && rd_valid_o;
  end

  // Payload RAM write port (no reset on storage)
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= rcv_dat_i;
    end
  end

  // Registered read data, one cycle after an honoured read strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      rdat_o <= 32'd0;
    end else if (!ctrl_busy && rd_fire) begin
      rdat_o <= ram[rd_addr];
    end
  end

  // Receive FSM, address pointers, sequence tracking and ACK request
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_addr    <= 9'd0;
      rd_addr    <= 9'd0;
      overflow   <= 1'b0;
      ack_num_o  <= 32'd0;
      ack_req_o  <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_len_o   <= 16'd0;
    end else if (controller_idle_st_i) begin
      // Controller idle flushes the buffer but keeps RCV.NXT
      state      <= ST_IDLE;
      wr_addr    <= 9'd0;
      rd_addr    <= 9'd0;
      overflow   <= 1'b0;
      ack_req_o  <= 1'b0;
      rd_valid_o <= 1'b0;
    end else if (init_i) begin
      // SYN received: restart sequence tracking with no ACK request
      state      <= ST_IDLE;
      wr_addr    <= 9'd0;
      rd_addr    <= 9'd0;
      overflow   <= 1'b0;
      ack_num_o  <= init_seq_i;
      ack_req_o  <= 1'b0;
      rd_valid_o <= 1'b0;
    end else begin
      // Every closed segment requests an ACK; non-commits produce a duplicate ACK
      ack_req_o <= eop_event;

      if (commit) begin
        rd_valid_o <= 1'b1;
        rd_len_o   <= rcv_len_i;
        ack_num_o  <= ack_num_o + {16'd0, rcv_len_i};
      end

      case (state)
        ST_IDLE: begin
          if (rcv_sop_i) begin
            if (sop_accept) begin
              wr_addr  <= 9'd1;
              overflow <= 1'b0;
            end
            if (!rcv_eop_i) begin
              state <= sop_accept ? ST_WRITE : ST_DROP;
            end
          end
        end
        ST_WRITE: begin
          if (write_word) begin
            wr_addr <= wr_addr + 9'd1;
            if (wr_addr == 9'd511) begin
              overflow <= 1'b1;
            end
          end
          if (rcv_eop_i) begin
            state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (rcv_eop_i) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // A failed segment leaves nothing behind in the write pointer
      if (drop_eop) begin
        wr_addr  <= 9'd0;
        overflow <= 1'b0;
      end

      if (rd_fire) begin
        rd_addr <= rd_addr + 9'd1;
      end

      // Release cannot coincide with a commit: commits need an empty buffer
      if (release_buf) begin
        rd_valid_o <= 1'b0;
        rd_addr    <= 9'd0;
        wr_addr    <= 9'd0;
      end
    end
  end

`ifdef TCP_RD_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating count of segments closed without commit; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= 16'd0;
    end else if (!ctrl_busy && drop_eop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_tcp_rd_memory.sv
// tb/tb_tcp_rd_memory.sv - randomized self-checking bench for tcp_rd_memory
module tb_tcp_rd_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        controller_idle_st_i;
  logic        init_i;
  logic [31:0] init_seq_i;
  logic        rcv_sop_i;
  logic        rcv_wr_i;
  logic [31:0] rcv_dat_i;
  logic        rcv_eop_i;
  logic [31:0] rcv_seq_num_i;
  logic [15:0] rcv_len_i;
  logic        rcv_chksum_ok_i;
  logic [31:0] ack_num_o;
  logic        ack_req_o;
  logic        rd_valid_o;
  logic [15:0] rd_len_o;
  logic        rd_i;
  logic [31:0] rdat_o;
  logic        rd_done_i;
  logic [15:0] drop_cnt_o;

  tcp_rd_memory dut (
    .clk                  (clk),
    .rst                  (rst),
    .controller_idle_st_i (controller_idle_st_i),
    .init_i               (init_i),
    .init_seq_i           (init_seq_i),
    .rcv_sop_i            (rcv_sop_i),
    .rcv_wr_i             (rcv_wr_i),
    .rcv_dat_i            (rcv_dat_i),
    .rcv_eop_i            (rcv_eop_i),
    .rcv_seq_num_i        (rcv_seq_num_i),
    .rcv_len_i            (rcv_len_i),
    .rcv_chksum_ok_i      (rcv_chksum_ok_i),
    .ack_num_o            (ack_num_o),
    .ack_req_o            (ack_req_o),
    .rd_valid_o           (rd_valid_o),
    .rd_len_o             (rd_len_o),
    .rd_i                 (rd_i),
    .rdat_o               (rdat_o),
    .rd_done_i            (rd_done_i),
    .drop_cnt_o           (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          ack_cnt = 0;
  logic [31:0] last_ack = 32'd0;

  // Reference model state
  logic [31:0] m_ack;
  bit          m_valid;
  logic [15:0] m_len;
  logic [31:0] m_words[$];
  int          m_drops;

  // ACK pulses sampled away from the active edge
  always @(negedge clk) begin
    if (ack_req_o) begin
      ack_cnt++;
      last_ack = ack_num_o;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_drop();
`ifdef TCP_RD_DROP_CNT_EN
    return (m_drops > 65535) ? 32'd65535 : 32'(m_drops);
`else
    return 32'd0;
`endif
  endfunction

  task automatic idle_inputs();
    rcv_sop_i       = 1'b0;
    rcv_wr_i        = 1'b0;
    rcv_eop_i       = 1'b0;
    rcv_dat_i       = $urandom;
    rcv_seq_num_i   = $urandom;
    rcv_len_i       = 16'($urandom);
    rcv_chksum_ok_i = 1'($urandom);
  endtask

  task automatic do_init(input logic [31:0] seq);
    int start;
    start = ack_cnt;
    init_i = 1'b1;
    init_seq_i = seq;
    tick();
    init_i = 1'b0;
    tick();
    m_ack = seq;
    m_valid = 1'b0;
    check_val("init_ack_num", ack_num_o, seq);
    check_val("init_no_ack_req", 32'(ack_cnt - start), 32'd0);
    check_val("init_rd_valid", {31'd0, rd_valid_o}, 32'd0);
  endtask

  task automatic send_segment(input logic [31:0] seq, input int nwords,
                              input logic [15:0] len, input bit ok);
    logic [31:0] words[$];
    bit          accept;
    bit          commit;
    int          start;
    accept = !m_valid && (seq == m_ack);
    commit = accept && ok && (len != 0) && (int'(len) <= 1450) &&
             ((int'(len) + 3) / 4 == nwords);
    start = ack_cnt;
    for (int i = 0; i < nwords; i++) begin
      if (i > 0 && ($urandom % 4) == 0) begin
        idle_inputs();
        tick();
      end
      words.push_back($urandom);
      idle_inputs();
      rcv_sop_i = (i == 0);
      rcv_wr_i  = 1'b1;
      rcv_dat_i = words[i];
      if (i == 0) rcv_seq_num_i = seq;
      if (i == nwords - 1) begin
        rcv_eop_i       = 1'b1;
        rcv_len_i       = len;
        rcv_chksum_ok_i = ok;
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
    if (commit) begin
      m_valid = 1'b1;
      m_len   = len;
      m_ack   = m_ack + {16'd0, len};
      m_words = words;
    end else begin
      m_drops++;
    end
    check_val("seg_ack_req_count", 32'(ack_cnt - start), 32'd1);
    check_val("seg_ack_req_value", last_ack, m_ack);
    check_val("seg_ack_num", ack_num_o, m_ack);
    check_val("seg_rd_valid", {31'd0, rd_valid_o}, {31'd0, m_valid});
    if (m_valid) check_val("seg_rd_len", {16'd0, rd_len_o}, {16'd0, m_len});
    check_val("seg_drop_cnt", {16'd0, drop_cnt_o}, exp_drop());
  endtask

  task automatic read_segment();
    check_val("rd_valid_before_read", {31'd0, rd_valid_o}, 32'd1);
    for (int i = 0; i < m_words.size(); i++) begin
      rd_i = 1'b1;
      tick();
      check_val("rd_word", rdat_o, m_words[i]);
      if (($urandom % 3) == 0) begin
        rd_i = 1'b0;
        tick();
      end
    end
    rd_i = 1'b0;
    rd_done_i = 1'b1;
    tick();
    rd_done_i = 1'b0;
    m_valid = 1'b0;
    check_val("rd_done_valid", {31'd0, rd_valid_o}, 32'd0);
  endtask

  // Random segment length consistent with nwords, or deliberately not
  function automatic logic [15:0] pick_len(input int nwords);
    int mode;
    mode = $urandom % 6;
    if (mode == 0) return 16'(nwords * 4 + 1 + ($urandom % 4));
    if (mode == 1) return 16'd0;
    return 16'((nwords - 1) * 4 + 1 + ($urandom % 4));
  endfunction

  initial begin
    int start;
    rst = 1'b1;
    controller_idle_st_i = 1'b0;
    init_i = 1'b0;
    init_seq_i = 32'd0;
    rd_i = 1'b0;
    rd_done_i = 1'b0;
    idle_inputs();
    m_ack = 32'd0;
    m_valid = 1'b0;
    m_len = 16'd0;
    m_drops = 0;
    repeat (3) tick();
    check_val("rst_ack_num", ack_num_o, 32'd0);
    check_val("rst_ack_req", {31'd0, ack_req_o}, 32'd0);
    check_val("rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
    check_val("rst_rd_len", {16'd0, rd_len_o}, 32'd0);
    check_val("rst_rdat", rdat_o, 32'd0);
    check_val("rst_drop_cnt", {16'd0, drop_cnt_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic in-order commit, held buffer, release and resend
    do_init(32'h0000_1000);
    send_segment(32'h0000_1000, 3, 16'd10, 1'b1);
    check_val("dir_ack_100a", ack_num_o, 32'h0000_100A);
    send_segment(32'h0000_100A, 3, 16'd10, 1'b1);
    read_segment();
    send_segment(32'h0000_100A, 3, 16'd10, 1'b1);
    check_val("dir_ack_1014", ack_num_o, 32'h0000_1014);
    read_segment();

    // Out-of-order, bad checksum, oversize
    do_init(32'h0000_2000);
    send_segment(32'h0000_2400, 25, 16'd100, 1'b1);
    send_segment(32'h0000_2000, 3, 16'd10, 1'b0);
    send_segment(32'h0000_2000, 363, 16'd1451, 1'b1);
    send_segment(32'h0000_2000, 363, 16'd1450, 1'b1);
    read_segment();

    // Sequence wraparound and single-word segment
    do_init(32'hFFFF_FFF8);
    send_segment(32'hFFFF_FFF8, 4, 16'd16, 1'b1);
    check_val("dir_ack_wrap", ack_num_o, 32'h0000_0008);
    read_segment();
    send_segment(m_ack, 1, 16'd3, 1'b1);
    read_segment();

    // Controller idle flushes a committed segment
    send_segment(m_ack, 2, 16'd8, 1'b1);
    controller_idle_st_i = 1'b1;
    tick();
    controller_idle_st_i = 1'b0;
    tick();
    m_valid = 1'b0;
    check_val("idle_clears_valid", {31'd0, rd_valid_o}, 32'd0);
    check_val("idle_keeps_ack", ack_num_o, m_ack);

    // Controller idle mid-WRITE aborts the segment; a stray eop afterwards is ignored
    start = ack_cnt;
    idle_inputs();
    rcv_sop_i = 1'b1; rcv_wr_i = 1'b1; rcv_seq_num_i = m_ack;
    tick();
    idle_inputs();
    rcv_wr_i = 1'b1;
    tick();
    idle_inputs();
    controller_idle_st_i = 1'b1;
    tick();
    controller_idle_st_i = 1'b0;
    rcv_wr_i = 1'b1; rcv_eop_i = 1'b1; rcv_len_i = 16'd12; rcv_chksum_ok_i = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    check_val("midwrite_rd_valid", {31'd0, rd_valid_o}, 32'd0);
    check_val("midwrite_no_ack_req", 32'(ack_cnt - start), 32'd0);
    check_val("midwrite_ack_num", ack_num_o, m_ack);
    send_segment(m_ack, 5, 16'd18, 1'b1);
    read_segment();

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      int op;
      int nw;
      logic [31:0] seq;
      op = $urandom % 10;
      if (op == 0) begin
        do_init((($urandom % 2) == 0) ? (32'hFFFF_FFE0 + 32'($urandom % 16)) : 32'($urandom));
      end else if (op <= 3 && m_valid) begin
        read_segment();
      end else begin
        nw  = 1 + ($urandom % 8);
        seq = (($urandom % 4) == 0) ? (m_ack + 32'(1 + ($urandom % 64))) : m_ack;
        send_segment(seq, nw, pick_len(nw), ($urandom % 8) != 0);
      end
    end

    check_val("final_drop_cnt", {16'd0, drop_cnt_o}, exp_drop());
    check_val("final_ack_num", ack_num_o, m_ack);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
